// File: rtl/as_gpio_arb.sv
// GPIO write-bus arbiter: two one-entry capture slots (core, debug) sharing one registered bus,
// round-robin grant with a debug lock, programmable strobe length plus a mandatory idle cycle.
module as_gpio_arb #(
  parameter int unsigned nr_gpios        = 8,
  parameter int unsigned gpio_addr_width = 8,
  parameter int unsigned HOLD_CYCLES     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // core store path
  input  logic                       c_valid_i,
  output logic                       c_ready_o,
  input  logic [gpio_addr_width-1:0] c_addr_i,
  input  logic [nr_gpios-1:0]        c_data_i,
  output logic                       c_done_o,
  // debug path
  input  logic                       d_valid_i,
  output logic                       d_ready_o,
  input  logic [gpio_addr_width-1:0] d_addr_i,
  input  logic [nr_gpios-1:0]        d_data_i,
  output logic                       d_done_o,
  input  logic                       d_lock_i,
  // shared bus
  output logic                       grant_o,
  output logic [nr_gpios-1:0]        gpio_o,
  output logic [gpio_addr_width-1:0] gpioAddr_o,
  output logic                       cs_o
);

  localparam int unsigned CntW = ($clog2(HOLD_CYCLES + 1) > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("as_gpio_arb: HOLD_CYCLES must be at least 1");
  end

  typedef enum logic {StIdle = 1'b0, StDrive = 1'b1} state_e;

  // Slot registers
  logic                       r_c_full, r_d_full;
  logic [gpio_addr_width-1:0] r_c_addr, r_d_addr;
  logic [nr_gpios-1:0]        r_c_data, r_d_data;

  // Sequencer registers
  state_e                     r_state;
  logic [CntW-1:0]            r_cnt;
  logic                       r_last_grant;
  logic                       r_grant;
  logic                       r_cs;
  logic [nr_gpios-1:0]        r_gpio;
  logic [gpio_addr_width-1:0] r_gpio_addr;

  // Next-state and decode
  state_e                     w_state_d;
  logic [CntW-1:0]            w_cnt_d;
  logic                       w_last_grant_d;
  logic                       w_grant_d;
  logic                       w_cs_d;
  logic [nr_gpios-1:0]        w_gpio_d;
  logic [gpio_addr_width-1:0] w_gpio_addr_d;
  logic                       w_c_elig, w_d_elig, w_winner;
  logic                       w_take_c, w_take_d;
  logic                       w_cap_c, w_cap_d;

  assign w_c_elig = r_c_full & ~d_lock_i;
  assign w_d_elig = r_d_full;
  // On a tie the requester that did not own the previous transfer wins.
  assign w_winner = (w_c_elig & w_d_elig) ? ~r_last_grant : w_d_elig;

  assign w_cap_c = c_valid_i & ~r_c_full;
  assign w_cap_d = d_valid_i & ~r_d_full;

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_last_grant_d = r_last_grant;
    w_grant_d      = r_grant;
    w_cs_d         = r_cs;
    w_gpio_d       = r_gpio;
    w_gpio_addr_d  = r_gpio_addr;
    w_take_c       = 1'b0;
    w_take_d       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_c_elig || w_d_elig) begin
          w_take_c       = ~w_winner;
          w_take_d       = w_winner;
          w_gpio_d       = w_winner ? r_d_data : r_c_data;
          w_gpio_addr_d  = w_winner ? r_d_addr : r_c_addr;
          w_grant_d      = w_winner;
          w_last_grant_d = w_winner;
          w_cs_d         = 1'b1;
          w_cnt_d        = CntLoad;
          w_state_d      = StDrive;
        end
      end
      StDrive: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CntW'(1);
        end else begin
          // Dropping cs_o here guarantees an idle bus cycle between transfers.
          w_cs_d    = 1'b0;
          w_state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c_full <= 1'b0;
      r_c_addr <= '0;
      r_c_data <= '0;
    end else if (w_cap_c) begin
      r_c_full <= 1'b1;
      r_c_addr <= c_addr_i;
      r_c_data <= c_data_i;
    end else if (w_take_c) begin
      r_c_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_d_full <= 1'b0;
      r_d_addr <= '0;
      r_d_data <= '0;
    end else if (w_cap_d) begin
      r_d_full <= 1'b1;
      r_d_addr <= d_addr_i;
      r_d_data <= d_data_i;
    end else if (w_take_d) begin
      r_d_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cs         <= 1'b0;
      r_gpio       <= '0;
      r_gpio_addr  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_last_grant <= w_last_grant_d;
      r_grant      <= w_grant_d;
      r_cs         <= w_cs_d;
      r_gpio       <= w_gpio_d;
      r_gpio_addr  <= w_gpio_addr_d;
    end
  end

  assign c_ready_o  = ~r_c_full;
  assign d_ready_o  = ~r_d_full;
  assign grant_o    = r_grant;
  assign gpio_o     = r_gpio;
  assign gpioAddr_o = r_gpio_addr;
  assign cs_o       = r_cs;
  assign c_done_o   = (r_state == StDrive) & (r_cnt == '0) & ~r_grant;
  assign d_done_o   = (r_state == StDrive) & (r_cnt == '0) & r_grant;

endmodule

// File: tb/tb_as_gpio_arb.sv
// Directed vector bench for as_gpio_arb: instance A at HOLD_CYCLES=1, instance B at HOLD_CYCLES=3.
module tb_as_gpio_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_cv, a_cr, a_cdn, a_dv, a_dr, a_ddn, a_lk, a_gr, a_cs;
  logic [7:0] a_ca, a_cd, a_da, a_dd, a_g, a_ga;
  logic       b_rst, b_cv, b_cr, b_cdn, b_dv, b_dr, b_ddn, b_lk, b_gr, b_cs;
  logic [7:0] b_ca, b_cd, b_da, b_dd, b_g, b_ga;

  as_gpio_arb #(.nr_gpios(8), .gpio_addr_width(8), .HOLD_CYCLES(1)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .c_valid_i(a_cv), .c_ready_o(a_cr), .c_addr_i(a_ca), .c_data_i(a_cd), .c_done_o(a_cdn),
    .d_valid_i(a_dv), .d_ready_o(a_dr), .d_addr_i(a_da), .d_data_i(a_dd), .d_done_o(a_ddn),
    .d_lock_i(a_lk), .grant_o(a_gr), .gpio_o(a_g), .gpioAddr_o(a_ga), .cs_o(a_cs)
  );

  as_gpio_arb #(.nr_gpios(8), .gpio_addr_width(8), .HOLD_CYCLES(3)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .c_valid_i(b_cv), .c_ready_o(b_cr), .c_addr_i(b_ca), .c_data_i(b_cd), .c_done_o(b_cdn),
    .d_valid_i(b_dv), .d_ready_o(b_dr), .d_addr_i(b_da), .d_data_i(b_dd), .d_done_o(b_ddn),
    .d_lock_i(b_lk), .grant_o(b_gr), .gpio_o(b_g), .gpioAddr_o(b_ga), .cs_o(b_cs)
  );

  typedef struct {
    logic       rst, cv;
    logic [7:0] ca, cd;
    logic       dv;
    logic [7:0] da, dd;
    logic       lk;
    logic       cs;
    logic [7:0] g, ga;
    logic       gr, cr, dr, cdn, ddn;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic rst, input logic cv, input logic [7:0] ca,
                              input logic [7:0] cd, input logic dv, input logic [7:0] da,
                              input logic [7:0] dd, input logic lk, input logic cs,
                              input logic [7:0] g, input logic [7:0] ga, input logic gr,
                              input logic cr, input logic dr, input logic cdn, input logic ddn);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ca = ca; v.cd = cd; v.dv = dv; v.da = da; v.dd = dd; v.lk = lk;
    v.cs = cs; v.g = g; v.ga = ga; v.gr = gr; v.cr = cr; v.dr = dr; v.cdn = cdn; v.ddn = ddn;
    return v;
  endfunction

  task automatic drive(input bit sel, input vec_t v);
    if (!sel) begin
      a_rst = v.rst; a_cv = v.cv; a_ca = v.ca; a_cd = v.cd;
      a_dv = v.dv; a_da = v.da; a_dd = v.dd; a_lk = v.lk;
    end else begin
      b_rst = v.rst; b_cv = v.cv; b_ca = v.ca; b_cd = v.cd;
      b_dv = v.dv; b_da = v.da; b_dd = v.dd; b_lk = v.lk;
    end
  endtask

  task automatic check(input string nm, input bit sel, input vec_t v);
    logic [20:0] act, exp;
    act = sel ? {b_cs, b_g, b_ga, b_gr, b_cr, b_dr, b_cdn, b_ddn}
              : {a_cs, a_g, a_ga, a_gr, a_cr, a_dr, a_cdn, a_ddn};
    exp = {v.cs, v.g, v.ga, v.gr, v.cr, v.dr, v.cdn, v.ddn};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {cs,gpio,addr,grant,c_rdy,d_rdy,c_done,d_done} got %h required %h",
               nm, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    logic [7:0] e;
    idle = mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,0,0,0,0);
    drive(0, idle); drive(1, idle);
    a_rst = 1'b1; b_rst = 1'b1;

    //         rst cv ca     cd     dv da     dd     lk  cs g      ga     gr cr dr cd dd
    // A: single write, tie order, lock
    va.push_back(mk(1,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    va.push_back(mk(0,1,8'h04,8'h37,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,0,1,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h37,8'h04,0,1,1,1,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h37,8'h04,0,1,1,0,0));
    va.push_back(mk(1,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    va.push_back(mk(0,1,8'h04,8'h02,1,8'h05,8'h00,0, 0,8'h00,8'h00,0,0,0,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h02,8'h04,0,1,0,1,0));
    va.push_back(mk(0,1,8'h06,8'h55,0,8'h00,8'h00,0, 0,8'h02,8'h04,0,0,0,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h00,8'h05,1,0,1,0,1));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h05,1,0,1,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h55,8'h06,0,1,1,1,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h55,8'h06,0,1,1,0,0));
    va.push_back(mk(0,1,8'h07,8'hAA,0,8'h00,8'h00,1, 0,8'h55,8'h06,0,0,1,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,1,8'h01,8'h11,1, 0,8'h55,8'h06,0,0,0,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,1, 1,8'h11,8'h01,1,0,1,0,1));
    va.push_back(mk(0,0,8'h00,8'h00,1,8'h02,8'h22,1, 0,8'h11,8'h01,1,0,0,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,1, 1,8'h22,8'h02,1,0,1,0,1));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h22,8'h02,1,0,1,0,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'hAA,8'h07,0,1,1,1,0));
    va.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'hAA,8'h07,0,1,1,0,0));

    // B: 3-cycle strobes back to back, lock during drive, reset mid-transfer
    vb.push_back(mk(1,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    vb.push_back(mk(0,1,8'h01,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h00,8'h01,0,1,1,0,0));
    vb.push_back(mk(0,1,8'h02,8'h02,0,8'h00,8'h00,0, 1,8'h00,8'h01,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h00,8'h01,0,0,1,1,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h01,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h02,8'h02,0,1,1,0,0));
    vb.push_back(mk(0,1,8'h03,8'h37,0,8'h00,8'h00,0, 1,8'h02,8'h02,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h02,8'h02,0,0,1,1,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h02,8'h02,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 1,8'h37,8'h03,0,1,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,1, 1,8'h37,8'h03,0,1,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,1, 1,8'h37,8'h03,0,1,1,1,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,1, 0,8'h37,8'h03,0,1,1,0,0));
    vb.push_back(mk(0,1,8'h04,8'h44,0,8'h00,8'h00,0, 0,8'h37,8'h03,0,0,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,1,8'h09,8'h99,0, 1,8'h44,8'h04,0,1,0,0,0));
    vb.push_back(mk(1,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));
    vb.push_back(mk(0,0,8'h00,8'h00,0,8'h00,8'h00,0, 0,8'h00,8'h00,0,1,1,0,0));

    repeat (2) @(posedge clk);
    #1;
    foreach (va[i]) begin
      drive(0, va[i]);
      @(posedge clk); #1;
      check($sformatf("A%0d", i), 0, va[i]);
    end
    drive(0, idle);
    foreach (vb[i]) begin
      drive(1, vb[i]);
      @(posedge clk); #1;
      check($sformatf("B%0d", i), 1, vb[i]);
    end
    drive(1, idle);

    // Continuous core refill at HOLD_CYCLES=1: strobe every other cycle, data in order.
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0; a_cv = 1'b1; a_ca = 8'h0C;
    for (int k = 1; k <= 8; k++) begin
      a_cd = 8'(k);
      @(posedge clk); #1;
      n_tests++;
      if (a_cs !== ((k % 2) == 0)) begin
        n_fail++;
        $display("FAIL stream_cs[%0d]: cs got %b required %b", k, a_cs, ((k % 2) == 0));
      end
      if ((k % 2) == 0) begin
        e = 8'(k - 1);
        n_tests++;
        if (a_g !== e || a_cdn !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: gpio/done got %h/%b required %h/1", k, a_g, a_cdn, e);
        end
      end
    end
    drive(0, idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
